// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
// Also usable by the transmit side.
package uart_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam logic [5:0] PRESCALE_8  = 6'd8;
    localparam logic [5:0] PRESCALE_16 = 6'd16;
    localparam logic [5:0] PRESCALE_32 = 6'd32;

endpackage

// File: rtl/edge_bit_counter.sv
// Oversample-edge and bit counters for one UART bit stream.
// clr has priority over en. bit_end flags the last oversample of a bit.
module edge_bit_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    input  logic [5:0] prescale,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       bit_end
);

    logic [5:0] edge_cnt_d, edge_cnt_q;
    logic [3:0] bit_cnt_d, bit_cnt_q;
    logic [5:0] edge_max;

    assign edge_max = prescale - 6'd1;

    always_comb begin
        edge_cnt_d = edge_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        bit_end    = en && (edge_cnt_q == edge_max);
        if (clr) begin
            edge_cnt_d = '0;
            bit_cnt_d  = '0;
        end else if (en) begin
            if (edge_cnt_q == edge_max) begin
                edge_cnt_d = '0;
                bit_cnt_d  = bit_cnt_q + 4'd1;
            end else begin
                edge_cnt_d = edge_cnt_q + 6'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt_q <= '0;
            bit_cnt_q  <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
        end
    end

    assign edge_cnt = edge_cnt_q;
    assign bit_cnt  = bit_cnt_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: frame FSM, LSB-first deserializer, parity/stop checks.
// Drives the majority sampler and reports each good byte with a one-cycle data_valid.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [5:0]            edge_cnt,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output logic                  busy,
    output rx_state_e             dbg_state
);

    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    rx_state_e             state_d, state_q;
    logic [DATA_WIDTH-1:0] p_data_d, p_data_q;
    logic                  par_en_d, par_en_q;
    logic                  par_typ_d, par_typ_q;
    logic                  par_err_d, par_err_q;
    logic                  stp_err_d, stp_err_q;
    logic                  data_valid_d, data_valid_q;
    logic                  busy_d, busy_q;
    logic                  samp_en_d, samp_en_q;
    logic                  exp_par;

    logic       cnt_en, cnt_clr, bit_end;
    logic [3:0] bit_cnt;

    // Counter runs while framing and is held at zero on any cycle headed for IDLE,
    // so the edge entering START always starts from edge_cnt 0.
    assign cnt_en  = (state_q != ST_IDLE);
    assign cnt_clr = (state_d == ST_IDLE);

    edge_bit_counter u_cnt (
        .clk      (CLK),
        .rst_n    (RST),
        .en       (cnt_en),
        .clr      (cnt_clr),
        .prescale (Prescale),
        .edge_cnt (edge_cnt),
        .bit_cnt  (bit_cnt),
        .bit_end  (bit_end)
    );

    assign exp_par = (par_typ_q == PAR_ODD) ? ~^p_data_q : ^p_data_q;

    always_comb begin
        state_d      = state_q;
        p_data_d     = p_data_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_err_d    = par_err_q;
        stp_err_d    = stp_err_q;
        data_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d   = ST_START;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_err_d = 1'b0;
                    stp_err_d = 1'b0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d = sampled_bit ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    p_data_d = {sampled_bit, p_data_q[DATA_WIDTH-1:1]};
                    if (bit_cnt == LAST_DATA_BIT) begin
                        state_d = par_en_q ? ST_PARITY : ST_STOP;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    if (sampled_bit != exp_par) begin
                        par_err_d = 1'b1;
                    end
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (!sampled_bit) begin
                        stp_err_d = 1'b1;
                    end
                    if (sampled_bit && !stp_err_q && !par_err_q) begin
                        data_valid_d = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d    = (state_d != ST_IDLE);
        samp_en_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= ST_IDLE;
            p_data_q     <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= PAR_EVEN;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            samp_en_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_data_q     <= p_data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            samp_en_q    <= samp_en_d;
        end
    end

    assign dat_samp_en = samp_en_q;
    assign P_DATA      = p_data_q;
    assign data_valid  = data_valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a mid-bit sampler model and a byte scoreboard.
module tb_uart_rx_ctrl;
    import uart_rx_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx_in = 1'b1;
    logic [5:0] presc = PRESCALE_8;
    logic       par_en = 1'b0;
    logic       par_typ = PAR_EVEN;
    logic       samp = 1'b1;

    logic       dat_samp_en;
    logic [5:0] edge_cnt;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;
    logic       busy;
    rx_state_e  dbg_state;

    int n_checks = 0;
    int n_errs = 0;
    int cyc = 0;
    int start_cyc = 0;
    int valid_cnt = 0;
    int valid_cyc = 0;
    logic prev_dv = 1'b0;
    logic [7:0] exp_q[$];

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .CLK         (clk),
        .RST         (rst_n),
        .RX_IN       (rx_in),
        .Prescale    (presc),
        .PAR_EN      (par_en),
        .PAR_TYP     (par_typ),
        .sampled_bit (samp),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .P_DATA      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sampler model: takes the line at mid-bit, result held until the next bit.
    always @(posedge clk) begin
        if (dat_samp_en && edge_cnt == (presc >> 1)) samp <= rx_in;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errs++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every data_valid pops one expected byte.
    always @(negedge clk) begin
        logic [7:0] e;
        if (data_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
            n_checks++;
            assert (exp_q.size() > 0) else begin
                n_errs++;
                $error("FAIL unexpected_valid: got P_DATA=%0h expected no pulse", p_data);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                assert (p_data === e) else begin
                    n_errs++;
                    $error("FAIL p_data: got %0h expected %0h", p_data, e);
                end
            end
            n_checks++;
            assert (prev_dv === 1'b0) else begin
                n_errs++;
                $error("FAIL valid_width: got 2+ cycle pulse expected 1 cycle");
            end
        end
        prev_dv = data_valid;
    end

    // Drives start, data LSB-first, optional parity, stop; each bit lasts presc cycles.
    // A nonzero limit stops after that many bits, leaving the frame unfinished.
    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pbit,
                              input logic sbit, input int limit, input logic chk_entry);
        logic [10:0] bits;
        int n;
        bits = '1;
        bits[0] = 1'b0;
        bits[8:1] = d;
        if (pe) begin
            bits[9] = pbit;
            bits[10] = sbit;
            n = 11;
        end else begin
            bits[9] = sbit;
            n = 10;
        end
        for (int i = 0; i < n; i++) begin
            if (limit > 0 && i >= limit) break;
            rx_in = bits[i];
            if (i == 0) start_cyc = cyc + 1;
            for (int j = 0; j < int'(presc); j++) begin
                @(negedge clk);
                if (chk_entry && i == 0 && j == 0) begin
                    chk("entry_busy", 32'(busy), 32'd1);
                    chk("entry_samp_en", 32'(dat_samp_en), 32'd1);
                    chk("entry_edge_cnt", 32'(edge_cnt), 32'd0);
                    chk("entry_state", 32'(dbg_state), 32'(ST_START));
                end
            end
        end
    endtask

    task automatic wait_valid(input int target, input int budget);
        for (int i = 0; i < budget && valid_cnt < target; i++) @(negedge clk);
        n_checks++;
        assert (valid_cnt >= target) else begin
            n_errs++;
            $error("FAIL valid_timeout: got %0d pulses expected %0d", valid_cnt, target);
        end
    endtask

    initial begin
        logic [7:0] b;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("rst_edge_cnt", 32'(edge_cnt), 32'd0);
        chk("rst_p_data", 32'(p_data), 32'd0);
        chk("rst_valid", 32'(data_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_samp_en", 32'(dat_samp_en), 32'd0);
        chk("rst_par_err", 32'(par_err), 32'd0);
        chk("rst_stp_err", 32'(stp_err), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Prescale 8, no parity, 0xA5
        presc = PRESCALE_8; par_en = 1'b0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        wait_valid(1, 20);
        chk("lat_p8", 32'(valid_cyc - start_cyc), 32'd80);
        chk("a5_par_err", 32'(par_err), 32'd0);
        chk("a5_stp_err", 32'(stp_err), 32'd0);
        repeat (2) @(negedge clk);
        chk("a5_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("a5_busy", 32'(busy), 32'd0);

        // Prescale 16, even parity, correct parity bit
        presc = PRESCALE_16; par_en = 1'b1; par_typ = PAR_EVEN;
        b = 8'h3C;
        exp_q.push_back(b);
        send_frame(b, 1'b1, ^b, 1'b1, 0, 1'b1);
        wait_valid(2, 30);
        chk("lat_p16", 32'(valid_cyc - start_cyc), 32'd176);
        chk("3c_par_err", 32'(par_err), 32'd0);

        // Same byte with wrong parity: flagged, no pulse, byte register holds
        send_frame(b, 1'b1, ~^b, 1'b1, 0, 1'b0);
        repeat (4) @(negedge clk);
        chk("bad_par_err", 32'(par_err), 32'd1);
        chk("bad_par_stp", 32'(stp_err), 32'd0);
        chk("bad_par_nvalid", 32'(valid_cnt), 32'd2);
        chk("bad_par_p_data", 32'(p_data), 32'h3C);

        // Stop bit forced low
        presc = PRESCALE_8; par_en = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        rx_in = 1'b1;
        repeat (4) @(negedge clk);
        chk("stp_err_set", 32'(stp_err), 32'd1);
        chk("stp_par_err", 32'(par_err), 32'd0);
        chk("stp_nvalid", 32'(valid_cnt), 32'd2);
        chk("stp_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("stp_busy", 32'(busy), 32'd0);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        wait_valid(3, 20);
        chk("stp_err_clear", 32'(stp_err), 32'd0);
        repeat (2) @(negedge clk);

        // Start-bit glitch: 3 low cycles, back to IDLE at the first bit end
        presc = PRESCALE_8;
        rx_in = 1'b0;
        repeat (3) @(negedge clk);
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        chk("glitch_start", 32'(dbg_state), 32'(ST_START));
        chk("glitch_busy_hi", 32'(busy), 32'd1);
        @(negedge clk);
        chk("glitch_idle", 32'(dbg_state), 32'(ST_IDLE));
        chk("glitch_busy_lo", 32'(busy), 32'd0);
        chk("glitch_samp_en", 32'(dat_samp_en), 32'd0);
        chk("glitch_par_err", 32'(par_err), 32'd0);
        chk("glitch_stp_err", 32'(stp_err), 32'd0);
        chk("glitch_nvalid", 32'(valid_cnt), 32'd3);
        repeat (2) @(negedge clk);

        // Back-to-back frames, Prescale 32, odd parity
        presc = PRESCALE_32; par_en = 1'b1; par_typ = PAR_ODD;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'hFE);
        send_frame(8'h01, 1'b1, ~^8'h01, 1'b1, 0, 1'b1);
        send_frame(8'hFE, 1'b1, ~^8'hFE, 1'b1, 0, 1'b0);
        rx_in = 1'b1;
        wait_valid(5, 40);
        chk("b2b_par_err", 32'(par_err), 32'd0);
        chk("b2b_stp_err", 32'(stp_err), 32'd0);
        repeat (2) @(negedge clk);

        // Reset in the middle of data bit 4
        presc = PRESCALE_8; par_en = 1'b0; par_typ = PAR_EVEN;
        b = 8'h33;
        send_frame(b, 1'b0, 1'b0, 1'b1, 5, 1'b0);
        rx_in = b[4];
        repeat (4) @(negedge clk);
        chk("mid_state_data", 32'(dbg_state), 32'(ST_DATA));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_state", 32'(dbg_state), 32'(ST_IDLE));
        chk("arst_edge_cnt", 32'(edge_cnt), 32'd0);
        chk("arst_p_data", 32'(p_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_samp_en", 32'(dat_samp_en), 32'd0);
        chk("arst_valid", 32'(data_valid), 32'd0);
        rx_in = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.push_back(8'h55);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1, 0, 1'b1);
        wait_valid(6, 20);
        chk("lat_after_rst", 32'(valid_cyc - start_cyc), 32'd80);
        repeat (4) @(negedge clk);

        chk("total_valid", 32'(valid_cnt), 32'd6);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Receive-side controller of the UART RX path. Detects the start bit and steps through the frame START → DATA → [PARITY] → STOP. Drives `dat_samp_en` and `edge_cnt` to the 3-sample majority sampler, and consumes its `sampled_bit`. Deserializes 8 data bits LSB-first, checks parity and stop, and presents a parallel byte with a one-cycle `data_valid` to the RX-side synchronizer/register file.

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `CLK`  in  1  oversampling clock (Prescale × baud).
- `RST`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, already 2-FF synchronized, idle high.
- `Prescale`  in  6  oversampling ratio; legal values 8, 16, 32; must be held stable while not IDLE.
- `PAR_EN`  in  1  parity bit present.
- `PAR_TYP`  in  1  0 = even, 1 = odd.
- `sampled_bit`  in  1  majority-voted bit from the sampler; valid from `edge_cnt == Prescale/2+2` until the end of the bit.
- `dat_samp_en`  out  1  sampler enable; high in START/DATA/PARITY/STOP.
- `edge_cnt`  out  6  oversample index within the current bit, 0..Prescale-1.
- `P_DATA`  out  DATA_WIDTH  received byte; holds its value until the next frame's DATA state.
- `data_valid`  out  1  one-cycle pulse; `P_DATA` is good.
- `par_err`  out  1  parity mismatch in the current/last frame.
- `stp_err`  out  1  stop bit sampled 0 in the current/last frame.
- `busy`  out  1  high when not IDLE.

## Operation
- Reset: state IDLE. `edge_cnt`=0, bit_cnt=0, `P_DATA`=0. `dat_samp_en`, `data_valid`, `par_err`, `stp_err`, `busy` all 0.
- Counters: `edge_cnt` increments every cycle while not IDLE. It wraps Prescale-1 → 0, and bit_cnt (4 bits) increments on each wrap. Both are forced to 0 in IDLE. Widths are fixed; Prescale-1 is computed in 6 bits.
- Bit decision point ("bit end"): the cycle where `edge_cnt == Prescale-1`. `sampled_bit` is read only at bit end.
- IDLE: when `RX_IN == 0`, go to START on the next edge with `edge_cnt`=0. At the same edge, latch `PAR_EN`/`PAR_TYP` and clear `par_err`/`stp_err`.
- START: at bit end, if `sampled_bit == 1` (glitch), return to IDLE with no flags set. Otherwise go to DATA.
- DATA: at each bit end, shift `sampled_bit` in LSB-first (shift right, new bit into MSB). After DATA_WIDTH bits, go to PARITY if `PAR_EN`, else STOP.
- PARITY: at bit end, expected = ^P_DATA (even) or ~^P_DATA (odd). Set `par_err`=1 if `sampled_bit` differs. Always proceed to STOP.
- STOP: at bit end:
  - If `sampled_bit == 0`, set `stp_err`=1.
  - If `stp_err` is still 0 and `par_err` is 0, pulse `data_valid`.
  - Go to IDLE in all cases.
- Errored frames never assert `data_valid`. Error flags hold until the next start bit.
- Back-to-back frames: a start edge present in the first IDLE cycle is accepted, adding 1 cycle of idle overhead.
- Reset mid-frame: immediate return to reset values. A partial byte is never reported.

## Timing
- All outputs are registered. `dat_samp_en`/`busy` rise on the edge that enters START.
- `data_valid` is high for exactly the one cycle after the STOP bit-end edge. `P_DATA` is stable in that cycle.
- Frame length from the entry into START to `data_valid`: (10 + PAR_EN) × Prescale cycles.
- `par_err` updates on the PARITY bit-end edge; `stp_err` on the STOP bit-end edge.

## Structure
- Shared package `uart_rx_pkg`:
  - State encodings: IDLE, START, DATA, PARITY, STOP (3-bit).
  - Parity constants EVEN=0, ODD=1.
  - Legal prescale constants.
- Sub-module `edge_bit_counter`: holds `edge_cnt` and bit_cnt with enable and wrap. It is instantiated once and also reusable by the TX side.
- FSM, deserializer shift register and parity/stop checks live in the top.

## Test plan
- Prescale=8, PAR_EN=0, send 0xA5 → `data_valid` 80 cycles after the start edge, `P_DATA`=0xA5, both errors 0.
- Prescale=16, PAR_EN=1, PAR_TYP=0, send 0x3C with parity 0 → `P_DATA`=0x3C, `data_valid` after 176 cycles. Repeat with parity 1 → `par_err`=1, no `data_valid`.
- Prescale=8, stop bit forced 0 → `stp_err`=1, no `data_valid`, state IDLE. The next good frame clears `stp_err`.
- RX_IN low for 3 cycles then high (glitch), Prescale=8 → returns to IDLE after 8 cycles; `data_valid`, `par_err`, `stp_err` stay 0.
- Two frames back-to-back, 0x01 then 0xFE at Prescale=32, parity odd → two `data_valid` pulses with correct bytes.
- RST asserted during DATA bit 4 → all outputs 0 asynchronously. The next full frame 0x55 is received correctly.
